lif_neuron_scheduler: RTL and testbench



---
 rtl/lif_pkg.sv | 20 ++
 rtl/lif_neuron_scheduler_if.sv | 27 ++
 rtl/lif_update_datapath.sv | 30 +++
 rtl/lif_neuron_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_lif_neuron_scheduler.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lif_pkg.sv
// Shared types and constants for the time-multiplexed LIF neuron scheduler.
// Holds the FSM state encoding, the config register map and the config reset values.
package lif_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_UPDATE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam logic [1:0] CFG_THRESH = 2'd0;
   localparam logic [1:0] CFG_LEAK   = 2'd1;
   localparam logic [1:0] CFG_EN     = 2'd2;
   localparam logic [1:0] CFG_CLR    = 2'd3;

   localparam int THRESH_RST = 128;
   localparam int LEAK_RST   = 2;

endpackage

// File: rtl/lif_neuron_scheduler_if.sv
// Config-write and input-current handshake bundle between the pin wrapper and the scheduler.
// The master modport is the scheduler; the slave modport is the wrapper/current source.
interface lif_neuron_scheduler_if #(
   parameter int NUM_NEURONS = 4,
   parameter int WIDTH       = 8
);
   localparam int ID_W = $clog2(NUM_NEURONS);

   logic             cfg_we;
   logic [1:0]       cfg_addr;
   logic [WIDTH-1:0] cfg_data;
   logic             cur_req;
   logic [ID_W-1:0]  cur_id;
   logic             cur_valid;
   logic [WIDTH-1:0] cur_data;

   modport master (
      output cur_req, cur_id,
      input  cfg_we, cfg_addr, cfg_data, cur_valid, cur_data
   );

   modport slave (
      input  cur_req, cur_id,
      output cfg_we, cfg_addr, cfg_data, cur_valid, cur_data
   );

endinterface

// File: rtl/lif_update_datapath.sv
// Combinational membrane update shared by all virtual neurons:
// leak by right shift, integrate the input current with saturation, compare to threshold.
module lif_update_datapath #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] v,
   input  logic [WIDTH-1:0] cur,
   input  logic [2:0]       leak_shift,
   input  logic [WIDTH-1:0] threshold,
   output logic [WIDTH-1:0] v_next,
   output logic             fire
);

   logic [WIDTH-1:0] leak_amt;
   logic [WIDTH-1:0] v_leak;
   logic [WIDTH:0]   sum;

   // NOTE: every signal driven here gets a value on every path, so no latch can be inferred.
   always_comb begin
      leak_amt = '0;
      if (leak_shift != 3'd0) begin
         leak_amt = v >> leak_shift;
      end
      v_leak = v - leak_amt;
      sum    = {1'b0, v_leak} + {1'b0, cur};
      v_next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      fire   = (v_next >= threshold);
   end

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Sweeps NUM_NEURONS virtual LIF neurons through one shared update datapath per tick,
// fetching each neuron's current over a req/valid handshake and publishing a spike vector.
module lif_neuron_scheduler
   import lif_pkg::*;
#(
   parameter int NUM_NEURONS  = 4,
   parameter int WIDTH        = 8,
   parameter int REFRAC_TICKS = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tick,
   lif_neuron_scheduler_if.master bus,
   output logic [NUM_NEURONS-1:0] spikes,
   output logic                   done,
   output logic                   busy,
   output logic                   overrun
);

   localparam int ID_W = $clog2(NUM_NEURONS);
   localparam int RC_W = (REFRAC_TICKS > 0) ? $clog2(REFRAC_TICKS + 1) : 1;
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_NEURONS - 1);
   localparam logic [RC_W-1:0] RC_LOAD = RC_W'(REFRAC_TICKS);

   state_e                 state_q, state_d;
   logic [ID_W-1:0]        n_q, n_d;
   logic [WIDTH-1:0]       v_q [NUM_NEURONS];
   logic [WIDTH-1:0]       v_d [NUM_NEURONS];
   logic [RC_W-1:0]        rc_q [NUM_NEURONS];
   logic [RC_W-1:0]        rc_d [NUM_NEURONS];
   logic [WIDTH-1:0]       cur_q, cur_d;
   logic [WIDTH-1:0]       thr_q, thr_d, thr_s_q, thr_s_d;
   logic [2:0]             leak_q, leak_d, leak_s_q, leak_s_d;
   logic [NUM_NEURONS-1:0] en_q, en_d, en_s_q, en_s_d;
   logic [NUM_NEURONS-1:0] acc_q, acc_d, spikes_q, spikes_d;
   logic                   done_q, done_d, busy_q, busy_d, overrun_q, overrun_d;
   logic                   cur_req_q, cur_req_d;
   logic [ID_W-1:0]        cur_id_q, cur_id_d;

   logic [WIDTH-1:0]             dp_v_next;
   logic                         dp_fire;
   logic [ID_W-1:0]              n_next;
   logic [NUM_NEURONS+WIDTH-1:0] cfg_ext;

   assign n_next  = n_q + 1'b1;
   assign cfg_ext = {{NUM_NEURONS{1'b0}}, bus.cfg_data};

   lif_update_datapath #(.WIDTH(WIDTH)) u_dp (
      .v          (v_q[n_q]),
      .cur        (cur_q),
      .leak_shift (leak_s_q),
      .threshold  (thr_s_q),
      .v_next     (dp_v_next),
      .fire       (dp_fire)
   );

   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      v_d       = v_q;
      rc_d      = rc_q;
      cur_d     = cur_q;
      thr_d     = thr_q;
      leak_d    = leak_q;
      en_d      = en_q;
      thr_s_d   = thr_s_q;
      leak_s_d  = leak_s_q;
      en_s_d    = en_s_q;
      acc_d     = acc_q;
      spikes_d  = spikes_q;
      done_d    = 1'b0;
      busy_d    = busy_q;
      overrun_d = overrun_q;
      cur_req_d = cur_req_q;
      cur_id_d  = cur_id_q;

      // The live config registers take every write; a sweep only ever sees its shadow copy.
      if (bus.cfg_we) begin
         case (bus.cfg_addr)
            CFG_THRESH: thr_d  = bus.cfg_data;
            CFG_LEAK:   leak_d = bus.cfg_data[2:0];
            CFG_EN:     en_d   = cfg_ext[NUM_NEURONS-1:0];
            default: begin
               if (state_q == ST_IDLE) begin
                  for (int i = 0; i < NUM_NEURONS; i++) begin
                     v_d[i]  = '0;
                     rc_d[i] = '0;
                  end
               end
            end
         endcase
      end

      if (tick && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               thr_s_d  = thr_q;
               leak_s_d = leak_q;
               en_s_d   = en_q;
               n_d      = '0;
               acc_d    = '0;
               busy_d   = 1'b1;
               if (en_q[0] && (rc_q[0] == '0)) begin
                  state_d   = ST_REQ;
                  cur_req_d = 1'b1;
                  cur_id_d  = '0;
               end else begin
                  state_d = ST_UPDATE;
               end
            end
         end

         ST_REQ: begin
            if (bus.cur_valid) begin
               cur_d     = bus.cur_data;
               cur_req_d = 1'b0;
               state_d   = ST_UPDATE;
            end
         end

         ST_UPDATE: begin
            if (en_s_q[n_q]) begin
               if (rc_q[n_q] != '0) begin
                  rc_d[n_q] = rc_q[n_q] - 1'b1;
                  v_d[n_q]  = '0;
               end else if (dp_fire) begin
                  acc_d[n_q] = 1'b1;
                  v_d[n_q]   = '0;
                  rc_d[n_q]  = RC_LOAD;
               end else begin
                  v_d[n_q] = dp_v_next;
               end
            end
            if (n_q == LAST_ID) begin
               state_d = ST_DONE;
            end else begin
               n_d = n_next;
               if (en_s_q[n_next] && (rc_q[n_next] == '0)) begin
                  state_d   = ST_REQ;
                  cur_req_d = 1'b1;
                  cur_id_d  = n_next;
               end else begin
                  state_d = ST_UPDATE;
               end
            end
         end

         default: begin
            spikes_d = acc_q;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state is updated only with non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         n_q       <= '0;
         // NOTE: the membrane file is reset explicitly because a fresh sweep must start
         // from V=0; a memory that may legally power up as garbage would skip this.
         for (int i = 0; i < NUM_NEURONS; i++) begin
            v_q[i]  <= '0;
            rc_q[i] <= '0;
         end
         cur_q     <= '0;
         thr_q     <= WIDTH'(THRESH_RST);
         leak_q    <= 3'(LEAK_RST);
         en_q      <= '1;
         thr_s_q   <= WIDTH'(THRESH_RST);
         leak_s_q  <= 3'(LEAK_RST);
         en_s_q    <= '1;
         acc_q     <= '0;
         spikes_q  <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         cur_req_q <= 1'b0;
         cur_id_q  <= '0;
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         v_q       <= v_d;
         rc_q      <= rc_d;
         cur_q     <= cur_d;
         thr_q     <= thr_d;
         leak_q    <= leak_d;
         en_q      <= en_d;
         thr_s_q   <= thr_s_d;
         leak_s_q  <= leak_s_d;
         en_s_q    <= en_s_d;
         acc_q     <= acc_d;
         spikes_q  <= spikes_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
         cur_req_q <= cur_req_d;
         cur_id_q  <= cur_id_d;
      end
   end

   assign bus.cur_req = cur_req_q;
   assign bus.cur_id  = cur_id_q;
   assign spikes      = spikes_q;
   assign done        = done_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Directed bench for lif_neuron_scheduler (N=4, WIDTH=8, REFRAC_TICKS=2) with
// hand-computed membrane, spike, latency and handshake expectations.
module tb_lif_neuron_scheduler;
   import lif_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic [3:0] spikes;
   logic       done, busy, overrun;
   logic [7:0] cur_val = 8'd0;
   logic [3:0] req_seen;
   int         n_pass = 0;
   int         n_checks = 0;
   int         lat;

   lif_neuron_scheduler_if #(.NUM_NEURONS(4), .WIDTH(8)) bus ();

   lif_neuron_scheduler #(.NUM_NEURONS(4), .WIDTH(8), .REFRAC_TICKS(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .bus     (bus),
      .spikes  (spikes),
      .done    (done),
      .busy    (busy),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   assign bus.cur_data = cur_val;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
      @(negedge clk);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = addr;
      bus.cfg_data = data;
      @(negedge clk);
      bus.cfg_we   = 1'b0;
   endtask

   // One tick, optional config write on the tick cycle, optional stray tick lat cycles in.
   task automatic sweep(input int extra_at, input bit cfg_with_tick,
                        input logic [1:0] addr, input logic [7:0] data, output int cycles);
      @(negedge clk);
      tick = 1'b1;
      if (cfg_with_tick) begin
         bus.cfg_we   = 1'b1;
         bus.cfg_addr = addr;
         bus.cfg_data = data;
      end
      @(posedge clk);
      #1;
      tick       = 1'b0;
      bus.cfg_we = 1'b0;
      req_seen   = '0;
      cycles     = 0;
      check("busy_after_tick", busy, 1);
      while (done !== 1'b1 && cycles < 100) begin
         if (bus.cur_req) req_seen[bus.cur_id] = 1'b1;
         if (cycles == extra_at) tick = 1'b1;
         @(posedge clk);
         #1;
         tick = 1'b0;
         cycles++;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = 2'd0;
      bus.cfg_data  = 8'd0;
      bus.cur_valid = 1'b1;
      req_seen      = '0;

      // Reset state
      do_reset();
      check("rst_cur_req", bus.cur_req, 0);
      check("rst_cur_id", bus.cur_id, 0);
      check("rst_spikes", spikes, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_v0", dut.v_q[0], 0);

      // Leak/integrate trajectory: thr=100, leak=2, cur=40 -> 40, 70, 93, spike
      cfg_write(CFG_THRESH, 8'd100);
      cur_val = 8'd40;
      sweep(-1, 0, 0, 0, lat);
      check("s1_latency", lat, 9);
      check("s1_v0", dut.v_q[0], 40);
      check("s1_spikes", spikes, 0);
      check("s1_busy_low", busy, 0);
      sweep(-1, 0, 0, 0, lat);
      check("s2_v0", dut.v_q[0], 70);
      sweep(-1, 0, 0, 0, lat);
      check("s3_v0", dut.v_q[0], 93);
      check("s3_spikes", spikes, 0);
      sweep(-1, 0, 0, 0, lat);
      check("s4_spikes", spikes, 4'b1111);
      check("s4_v0", dut.v_q[0], 0);
      sweep(-1, 0, 0, 0, lat);
      check("s5_refrac_spikes", spikes, 0);
      check("s5_refrac_latency", lat, 5);
      check("s5_refrac_noreq", req_seen, 0);
      sweep(-1, 0, 0, 0, lat);
      check("s6_refrac_spikes", spikes, 0);
      sweep(-1, 0, 0, 0, lat);
      check("s7_v0", dut.v_q[0], 40);
      check("s7_spikes", spikes, 0);
      cfg_write(CFG_CLR, 8'd0);
      check("clear_v0", dut.v_q[0], 0);
      check("clear_v3", dut.v_q[3], 0);

      // Saturation: V=200, no leak, cur=255 -> 255 which meets thr=255
      do_reset();
      cfg_write(CFG_THRESH, 8'd255);
      cfg_write(CFG_LEAK, 8'd0);
      cur_val = 8'd200;
      sweep(-1, 0, 0, 0, lat);
      check("sat_pre_v0", dut.v_q[0], 200);
      check("sat_pre_spikes", spikes, 0);
      cur_val = 8'd255;
      sweep(-1, 0, 0, 0, lat);
      check("sat_spikes", spikes, 4'b1111);
      check("sat_v0", dut.v_q[0], 0);

      // Threshold 0: every active neuron fires even with zero current
      do_reset();
      cfg_write(CFG_THRESH, 8'd0);
      cur_val = 8'd0;
      sweep(-1, 0, 0, 0, lat);
      check("thr0_spikes", spikes, 4'b1111);

      // cur_valid withheld 5 cycles on neuron 2
      do_reset();
      cur_val = 8'd40;
      @(negedge clk);
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      lat  = 0;
      while (!(bus.cur_req === 1'b1 && bus.cur_id == 2'd2) && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("stall_req_reached_at", lat, 4);
      bus.cur_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         lat++;
         check("stall_req_held", bus.cur_req, 1);
         check("stall_id_held", bus.cur_id, 2);
      end
      bus.cur_valid = 1'b1;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("stall_latency", lat, 14);
      check("stall_v2", dut.v_q[2], 40);

      // Stray tick mid-sweep and on the DONE cycle
      do_reset();
      check("ovr_clear_after_rst", overrun, 0);
      sweep(3, 0, 0, 0, lat);
      check("ovr_latency", lat, 9);
      check("ovr_set", overrun, 1);
      sweep(-1, 0, 0, 0, lat);
      check("ovr_sticky", overrun, 1);
      do_reset();
      sweep(8, 0, 0, 0, lat);
      check("ovr_done_set", overrun, 1);
      check("ovr_done_not_accepted", busy, 0);

      // Enable mask 0101
      do_reset();
      cfg_write(CFG_THRESH, 8'd255);
      cur_val = 8'd40;
      sweep(-1, 0, 0, 0, lat);
      check("en_pre_v1", dut.v_q[1], 40);
      cfg_write(CFG_THRESH, 8'd30);
      cfg_write(CFG_EN, 8'h05);
      sweep(-1, 0, 0, 0, lat);
      check("en_req_ids", req_seen, 4'b0101);
      check("en_spikes", spikes, 4'b0101);
      check("en_latency", lat, 7);
      check("en_v1_held", dut.v_q[1], 40);
      check("en_v3_held", dut.v_q[3], 40);

      // Config write coincident with tick: this sweep uses the old threshold
      do_reset();
      cur_val = 8'd100;
      sweep(-1, 1, CFG_THRESH, 8'd50, lat);
      check("cotick_spikes_old_thr", spikes, 0);
      check("cotick_v0", dut.v_q[0], 100);
      sweep(-1, 0, 0, 0, lat);
      check("cotick_spikes_new_thr", spikes, 4'b1111);

      // Reset during UPDATE of neuron 1
      do_reset();
      cfg_write(CFG_THRESH, 8'd50);
      cur_val = 8'd100;
      @(negedge clk);
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_in_update_n1", dut.n_q, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_cur_req", bus.cur_req, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_spikes", spikes, 0);
      check("midrst_v0", dut.v_q[0], 0);
      sweep(-1, 0, 0, 0, lat);
      check("midrst_latency", lat, 9);
      check("midrst_spikes_default_thr", spikes, 0);
      check("midrst_v0_after", dut.v_q[0], 100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
